// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_PRIO_EN to make requester 0 strict high priority at arbitration.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          gnt_vld,
  output logic [ID_W-1:0]               gnt_id,
  output logic [3:0]                    beat_cnt
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d, last_gnt_q, last_gnt_d, pick, lo, hi;
  logic [3:0] beat_cnt_q, beat_cnt_d, beat_inc;
  logic [DATA_WIDTH-1:0] sel_data;
  logic sel_valid, sel_last, hi_f, xfer, done;
  // lo is the lowest valid index, hi the lowest valid index above last_gnt; hi wins when present
  always_comb begin
    lo = '0;
    hi = '0;
    hi_f = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo = ID_W'(i);
        if (i > int'(last_gnt_q)) begin
          hi = ID_W'(i);
          hi_f = 1'b1;
        end
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    pick = req_valid[0] ? '0 : (hi_f ? hi : lo);
`else
    pick = hi_f ? hi : lo;
`endif
  end
  always_comb begin
    sel_data = '0;
    sel_valid = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == ID_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_valid[i];
        sel_last = req_last[i];
      end
    end
    xfer = (state_q == BURST) && sel_valid && !full && !rst;
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = xfer && (gnt_id_q == ID_W'(i));
    w_en = xfer;
    data_in = (state_q == BURST) ? sel_data : '0;
    beat_inc = beat_cnt_q + 4'd1;
    done = (state_q == BURST) && ((xfer && (sel_last || beat_inc == 4'(MAX_BURST))) || !sel_valid);
    state_d = state_q;
    gnt_id_d = gnt_id_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = xfer ? beat_inc : beat_cnt_q;
    if (state_q == IDLE && |req_valid) begin
      state_d = BURST;
      gnt_id_d = pick;
      beat_cnt_d = '0;
    end
    if (done) begin
      state_d = IDLE;
      beat_cnt_d = '0;
      last_gnt_d = gnt_id_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_id_q <= '0;
      beat_cnt_q <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_id_q <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end
  assign gnt_vld = (state_q == BURST);
  assign gnt_id = gnt_id_q;
  assign beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, MB = 4;
  logic clk = 1'b0, rst, full, w_en, gnt_vld;
  logic [3:0] req_valid, req_last, req_ready, beat_cnt;
  logic [31:0] req_data;
  logic [7:0] data_in;
  logic [1:0] gnt_id;
  int passed = 0, total = 0;
  bit m_busy;
  int m_id, m_cnt, m_last;
  logic s_wen, s_gv;
  logic [3:0] s_ready, s_cnt;
  logic [1:0] s_id;
  typedef struct {logic [3:0] v; bit gv; int id; int cnt; bit wen;} vec_t;
  vec_t vec[12];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8), .MAX_BURST(MB), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .full(full), .w_en(w_en), .data_in(data_in),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id), .beat_cnt(beat_cnt));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(bit r, logic [3:0] v, logic [3:0] l, bit f, bit do_chk);
    bit x;
    rst = r; req_valid = v; req_last = l; full = f; req_data = $urandom;
    @(negedge clk);
    s_wen = w_en; s_gv = gnt_vld; s_ready = req_ready; s_cnt = beat_cnt; s_id = gnt_id;
    x = m_busy && v[m_id] && !f && !r;
    if (do_chk) begin
      chk("w_en", 32'(w_en), 32'(x));
      chk("req_ready", 32'(req_ready), x ? 32'(1 << m_id) : 32'd0);
      chk("data_in", 32'(data_in), m_busy ? ((req_data >> (8 * m_id)) & 32'hFF) : 32'd0);
      chk("gnt_vld", 32'(gnt_vld), 32'(m_busy));
      chk("gnt_id", 32'(gnt_id), 32'(m_id));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    end
    if (r) begin
      m_busy = 0; m_id = 0; m_cnt = 0; m_last = N - 1;
    end else if (!m_busy) begin
      if (v != 0) begin
        for (int k = 1; k <= N; k++)
          if (v[(m_last + k) % N]) begin m_id = (m_last + k) % N; break; end
        m_busy = 1; m_cnt = 0;
      end
    end else begin
      if (x) m_cnt++;
      if ((x && (l[m_id] || m_cnt == MB)) || !v[m_id]) begin
        m_busy = 0; m_cnt = 0; m_last = m_id;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(1, 4'b0, 4'b0, 0, 0);
  endtask

  task automatic order_test(string name, logic [3:0] v, int n, int exp[6], int ne);
    int q[$];
    bit prev = 0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      step(0, v, 4'b0, 0, 1);
      chk({name, "_onehot"}, 32'($countones(s_ready) <= 1), 32'd1);
      if (s_gv && !prev) q.push_back(int'(s_id));
      prev = s_gv;
    end
    chk({name, "_grants"}, 32'(q.size()), 32'(ne));
    for (int i = 0; i < ne && i < q.size(); i++) chk({name, "_order"}, 32'(q[i]), 32'(exp[i]));
  endtask

  initial begin
    int w;
    vec[0]  = '{4'b0110, 0, 0, 0, 0};
    vec[1]  = '{4'b0110, 1, 1, 0, 1};
    vec[2]  = '{4'b0110, 1, 1, 1, 1};
    vec[3]  = '{4'b0110, 1, 1, 2, 1};
    vec[4]  = '{4'b0110, 1, 1, 3, 1};
    vec[5]  = '{4'b0110, 0, 1, 0, 0};
    vec[6]  = '{4'b0110, 1, 2, 0, 1};
    vec[7]  = '{4'b0110, 1, 2, 1, 1};
    vec[8]  = '{4'b0110, 1, 2, 2, 1};
    vec[9]  = '{4'b0110, 1, 2, 3, 1};
    vec[10] = '{4'b0110, 0, 2, 0, 0};
    vec[11] = '{4'b0110, 1, 1, 0, 1};
    rst = 1; req_valid = 0; req_last = 0; full = 0; req_data = 0;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, vec[i].v, 4'b0, 0, 1);
      chk("tbl_gnt_vld", 32'(s_gv), 32'(vec[i].gv));
      chk("tbl_gnt_id", 32'(s_id), 32'(vec[i].id));
      chk("tbl_beat_cnt", 32'(s_cnt), 32'(vec[i].cnt));
      chk("tbl_w_en", 32'(s_wen), 32'(vec[i].wen));
    end
    // last on the second beat ends the grant early
    do_reset();
    w = 0;
    step(0, 4'b0001, 4'b0, 0, 1); w += int'(s_wen);
    step(0, 4'b0001, 4'b0, 0, 1); w += int'(s_wen);
    step(0, 4'b0001, 4'b0001, 0, 1); w += int'(s_wen);
    chk("last_writes", 32'(w), 32'd2);
    step(0, 4'b0001, 4'b0, 0, 1);
    chk("last_release", 32'(s_gv), 32'd0);
    step(0, 4'b0001, 4'b0, 0, 1);
    chk("last_regrant", {31'd0, s_gv}, 32'd1);
    chk("last_regrant_id", 32'(s_id), 32'd0);
    // full stalls a granted requester without releasing it
    do_reset();
    step(0, 4'b1000, 4'b0, 0, 1);
    step(0, 4'b1000, 4'b0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1000, 4'b0, 1, 1);
      chk("full_w_en", 32'(s_wen), 32'd0);
      chk("full_ready", 32'(s_ready), 32'd0);
      chk("full_cnt", 32'(s_cnt), 32'd1);
      chk("full_id", 32'(s_id), 32'd3);
    end
    w = 0;
    for (int i = 0; i < 3; i++) begin step(0, 4'b1000, 4'b0, 0, 1); w += int'(s_wen); end
    chk("full_resume_writes", 32'(w), 32'd3);
    step(0, 4'b1000, 4'b0, 0, 1);
    chk("full_release", 32'(s_gv), 32'd0);
    // reset mid-burst drops the beat in flight
    do_reset();
    step(0, 4'b0100, 4'b0, 0, 1);
    step(0, 4'b0100, 4'b0, 0, 1);
    step(1, 4'b0100, 4'b0, 0, 1);
    chk("rst_w_en", 32'(s_wen), 32'd0);
    step(0, 4'b0110, 4'b0, 0, 1);
    chk("rst_gnt_vld", 32'(s_gv), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    step(0, 4'b0110, 4'b0, 0, 1);
    chk("rst_next_id", 32'(s_id), 32'd1);
    order_test("all4", 4'b1111, 25, '{0, 1, 2, 3, 0, 0}, 5);
`ifndef FIFO_ARB_PRIO_EN
    order_test("v1011", 4'b1011, 30, '{0, 1, 3, 0, 1, 3}, 6);
`endif
    do_reset();
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 99) == 0, 4'($urandom), 4'($urandom & $urandom), $urandom_range(0, 4) == 0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
